// File: rtl/exec_stage_if.sv
// ID/EX, MEM/WB and EX/MEM signal bundle for the execute stage.
// master drives the ID/EX side, slave is the execute stage.
interface exec_stage_if;
    logic [31:0] id_readData1;
    logic [31:0] id_readData2;
    logic [31:0] id_address;
    logic [31:0] id_pc;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [1:0]  id_aluCtrl;
    logic        id_regDst;
    logic        id_branch;
    logic        id_memRead;
    logic        id_memToReg;
    logic        id_memWrite;
    logic        id_aluSrc;
    logic        id_regWrite;
    logic        id_word;
    logic        id_exception;
    logic [31:0] id_faulty_address;
    logic        wb_regWrite;
    logic [4:0]  wb_destReg;
    logic [31:0] wb_data;
    logic        mem_stall;
    logic        flush;
    logic        stall_exec;
    logic [31:0] exm_aluResult;
    logic [31:0] exm_writeData;
    logic [31:0] exm_pc;
    logic [31:0] exm_faulty_address;
    logic [31:0] exm_branchTarget;
    logic [4:0]  exm_destReg;
    logic        exm_memRead;
    logic        exm_memWrite;
    logic        exm_memToReg;
    logic        exm_regWrite;
    logic        exm_word;
    logic        exm_exception;
    logic        exm_branchTaken;

    modport master (
        output id_readData1, id_readData2, id_address, id_pc,
        output id_rs, id_rt, id_rd, id_aluCtrl,
        output id_regDst, id_branch, id_memRead, id_memToReg,
        output id_memWrite, id_aluSrc, id_regWrite, id_word,
        output id_exception, id_faulty_address,
        output wb_regWrite, wb_destReg, wb_data,
        output mem_stall, flush,
        input  stall_exec,
        input  exm_aluResult, exm_writeData, exm_pc,
        input  exm_faulty_address, exm_branchTarget, exm_destReg,
        input  exm_memRead, exm_memWrite, exm_memToReg,
        input  exm_regWrite, exm_word, exm_exception, exm_branchTaken
    );

    modport slave (
        input  id_readData1, id_readData2, id_address, id_pc,
        input  id_rs, id_rt, id_rd, id_aluCtrl,
        input  id_regDst, id_branch, id_memRead, id_memToReg,
        input  id_memWrite, id_aluSrc, id_regWrite, id_word,
        input  id_exception, id_faulty_address,
        input  wb_regWrite, wb_destReg, wb_data,
        input  mem_stall, flush,
        output stall_exec,
        output exm_aluResult, exm_writeData, exm_pc,
        output exm_faulty_address, exm_branchTarget, exm_destReg,
        output exm_memRead, exm_memWrite, exm_memToReg,
        output exm_regWrite, exm_word, exm_exception, exm_branchTaken
    );
endinterface

// File: rtl/exec_stage.sv
// Execute stage: forwarding, ALU, branch resolution, iterative multiplier.
// Optional macro EX_OVERFLOW_TRAP_EN traps signed ADD/SUB overflow.
module exec_stage #(
    parameter int MUL_BITS_PER_CYCLE = 1
) (
    input  logic         clock,
    input  logic         reset_n,
    exec_stage_if.slave  bus
);
    localparam int N = MUL_BITS_PER_CYCLE;
    localparam int K = 32 / N;
    localparam logic [4:0] LAST = 5'(K - 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_MUL = 2'b11;

    typedef enum logic {IDLE, BUSY} state_t;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] wdata;
        logic [31:0] pc;
        logic [31:0] faddr;
        logic [31:0] target;
        logic [4:0]  dest;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        reg_write;
        logic        word;
        logic        exc;
        logic        taken;
    } exm_t;

    state_t      state;
    exm_t        exm;
    exm_t        cap;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [31:0] acc;
    logic [31:0] acc_nxt;
    logic [31:0] part;
    logic [4:0]  cnt;

    logic        ex_ok;
    logic        a_ex;
    logic        a_wb;
    logic        b_ex;
    logic        b_wb;
    logic [31:0] fwd_a;
    logic [31:0] fwd_b;
    logic [31:0] op_b;
    logic [31:0] sum;
    logic [31:0] diff;
    logic [31:0] alu_res;
    logic [31:0] target;
    logic [4:0]  dest;
    logic        taken;
    logic        mul_go;
    logic        trap;
    logic        exc;
    logic        stall;

    // A load in EX/MEM has no data yet, so it is never a forwarding source.
    assign ex_ok = exm.reg_write && !exm.mem_to_reg;

    assign a_ex = ex_ok && exm.dest == bus.id_rs
               && bus.id_rs != 5'd0;
    assign a_wb = bus.wb_regWrite && bus.wb_destReg == bus.id_rs
               && bus.id_rs != 5'd0;
    assign b_ex = ex_ok && exm.dest == bus.id_rt
               && bus.id_rt != 5'd0;
    assign b_wb = bus.wb_regWrite && bus.wb_destReg == bus.id_rt
               && bus.id_rt != 5'd0;

    assign fwd_a = a_ex ? exm.alu
                 : a_wb ? bus.wb_data
                 : bus.id_readData1;
    assign fwd_b = b_ex ? exm.alu
                 : b_wb ? bus.wb_data
                 : bus.id_readData2;

    assign op_b = bus.id_aluSrc ? bus.id_address : fwd_b;
    assign dest = bus.id_regDst ? bus.id_rd : bus.id_rt;
    assign sum  = fwd_a + op_b;
    assign diff = fwd_a - op_b;

    always_comb begin
        alu_res = '0;
        unique case (bus.id_aluCtrl)
            OP_ADD: alu_res = sum;
            OP_SUB: alu_res = diff;
            OP_AND: alu_res = fwd_a & op_b;
            OP_MUL: alu_res = '0;
        endcase
    end

    assign taken  = bus.id_branch && (fwd_a == fwd_b);
    assign target = bus.id_pc + 32'd4 + (bus.id_address << 2);
    assign mul_go = bus.id_aluCtrl == OP_MUL && !bus.id_exception;

`ifdef EX_OVERFLOW_TRAP_EN
    logic ovf;

    always_comb begin
        ovf = 1'b0;
        if (bus.id_aluCtrl == OP_ADD)
            ovf = fwd_a[31] == op_b[31] && sum[31] != fwd_a[31];
        else if (bus.id_aluCtrl == OP_SUB)
            ovf = fwd_a[31] != op_b[31] && diff[31] != fwd_a[31];
    end

    assign trap = ovf && !bus.id_exception;
`else
    assign trap = 1'b0;
`endif

    assign exc = bus.id_exception || trap;

    // Shift-add: retire N multiplier bits against the shifted multiplicand.
    always_comb begin
        part = '0;
        for (int i = 0; i < N; i++)
            if (mplier[i])
                part = part + (mcand << i);
    end

    assign acc_nxt = acc + part;

    always_comb begin
        cap            = '0;
        cap.alu        = (state == BUSY) ? acc_nxt : alu_res;
        cap.wdata      = fwd_b;
        cap.pc         = bus.id_pc;
        cap.faddr      = trap ? bus.id_pc : bus.id_faulty_address;
        cap.target     = target;
        cap.dest       = dest;
        cap.mem_read   = bus.id_memRead && !exc;
        cap.mem_write  = bus.id_memWrite && !exc;
        cap.mem_to_reg = bus.id_memToReg;
        cap.reg_write  = bus.id_regWrite && !exc;
        cap.word       = bus.id_word;
        cap.exc        = exc;
        cap.taken      = taken && !bus.id_exception;
    end

    always_comb begin
        stall = 1'b0;
        if (bus.flush)
            stall = 1'b0;
        else if (bus.mem_stall)
            stall = 1'b1;
        else if (state == BUSY)
            stall = cnt != LAST;
        else
            stall = mul_go;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            exm    <= '0;
            state  <= IDLE;
            acc    <= '0;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (bus.flush) begin
            exm   <= '0;
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
        end else if (!bus.mem_stall) begin
            unique case (state)
                IDLE: begin
                    if (mul_go) begin
                        exm    <= '0;
                        mcand  <= fwd_a;
                        mplier <= op_b;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= BUSY;
                    end else begin
                        exm <= cap;
                    end
                end
                BUSY: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << N;
                    mplier <= mplier >> N;
                    cnt    <= cnt + 5'd1;
                    if (cnt == LAST) begin
                        exm   <= cap;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.stall_exec         = stall;
    assign bus.exm_aluResult      = exm.alu;
    assign bus.exm_writeData      = exm.wdata;
    assign bus.exm_pc             = exm.pc;
    assign bus.exm_faulty_address = exm.faddr;
    assign bus.exm_branchTarget   = exm.target;
    assign bus.exm_destReg        = exm.dest;
    assign bus.exm_memRead        = exm.mem_read;
    assign bus.exm_memWrite       = exm.mem_write;
    assign bus.exm_memToReg       = exm.mem_to_reg;
    assign bus.exm_regWrite       = exm.reg_write;
    assign bus.exm_word           = exm.word;
    assign bus.exm_exception      = exm.exc;
    assign bus.exm_branchTaken    = exm.taken;
endmodule
